// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: register map, bit positions
// and the default baud divisor.
package uart_pkg;

   localparam logic [1:0] UART_ADDR_CTRL   = 2'd0;
   localparam logic [1:0] UART_ADDR_BAUD   = 2'd1;
   localparam logic [1:0] UART_ADDR_STATUS = 2'd2;
   localparam logic [1:0] UART_ADDR_DATA   = 2'd3;

   localparam int CTRL_RX_EN  = 0;
   localparam int CTRL_IRQ_EN = 1;

   localparam int STAT_NOT_EMPTY = 0;
   localparam int STAT_FULL      = 1;
   localparam int STAT_OVERRUN   = 2;
   localparam int STAT_FRAME_ERR = 3;
   localparam int STAT_COUNT_LSB = 4;

   localparam int UART_DIV_9600_100M = 10416;

   // The STATUS count field is three bits wide, so deeper FIFOs report 7.
   function automatic logic [2:0] sat_count(input logic [31:0] c);
      return (c > 32'd7) ? 3'd7 : c[2:0];
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous receive FIFO. Push and pop must already be qualified by the caller
// (no push when full without a pop, no pop when empty).
module uart_rx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       i_push,
   input  logic                       i_pop,
   input  logic [WIDTH-1:0]           i_wdata,
   output logic [WIDTH-1:0]           o_head,
   output logic                       o_full,
   output logic                       o_empty,
   output logic [$clog2(DEPTH):0]     o_count
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      end else begin
         if (i_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
            r_wr_ptr                <= r_wr_ptr + 1'b1;
         end
         if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   // Pointers carry one extra wrap bit: equal indices with differing wrap bits means full.
   assign o_head  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/uart_rx_ctrl.sv
// Register-mapped UART receive controller: CTRL/BAUD configuration, receive FIFO,
// sticky overrun/framing status and a registered level interrupt.
module uart_rx_ctrl
   import uart_pkg::*;
#(
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_RESET  = UART_DIV_9600_100M
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        rd_en,
   input  logic [1:0]  addr,
   input  logic [15:0] wr_data,
   output logic [15:0] rd_data,
   output logic        rd_valid,
   input  logic [7:0]  rx_byte,
   input  logic        rx_done,
   input  logic        rx_frame_err,
   output logic        rx_enable,
   output logic [13:0] baud_tick_max,
   output logic        irq
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic        r_rx_en;
   logic        r_irq_en;
   logic [13:0] r_baud;
   logic        r_overrun;
   logic        r_frame_err;
   logic [15:0] r_rd_data;
   logic        r_rd_valid;
   logic        r_irq;

   logic [7:0]  w_head;
   logic        w_full;
   logic        w_empty;
   logic [AW:0] w_count;
   logic        w_pop;
   logic        w_push_req;
   logic        w_push;
   logic        w_overrun_set;
   logic        w_frame_set;
   logic        w_wr_ctrl;
   logic        w_wr_baud;
   logic        w_wr_status;
   logic [15:0] w_status;
   logic [15:0] w_rd_mux;

   assign w_wr_ctrl   = wr_en && (addr == UART_ADDR_CTRL);
   assign w_wr_baud   = wr_en && (addr == UART_ADDR_BAUD);
   assign w_wr_status = wr_en && (addr == UART_ADDR_STATUS);

   // A pop on an empty FIFO is dropped so a same-cycle push still lands.
   assign w_pop         = rd_en && (addr == UART_ADDR_DATA) && !w_empty;
   assign w_push_req    = rx_done && r_rx_en && !rx_frame_err;
   assign w_push        = w_push_req && (!w_full || w_pop);
   assign w_overrun_set = w_push_req && w_full && !w_pop;
   assign w_frame_set   = rx_done && r_rx_en && rx_frame_err;

   uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (rx_byte),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty),
      .o_count (w_count)
   );

   assign w_status = {9'd0, sat_count(32'(w_count)), r_frame_err, r_overrun, w_full, !w_empty};

   always_comb begin
      w_rd_mux = '0;
      case (addr)
         UART_ADDR_CTRL:   w_rd_mux = {14'd0, r_irq_en, r_rx_en};
         UART_ADDR_BAUD:   w_rd_mux = {2'b00, r_baud};
         UART_ADDR_STATUS: w_rd_mux = w_status;
         UART_ADDR_DATA:   w_rd_mux = w_empty ? 16'd0 : {8'd0, w_head};
         default:          w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rx_en     <= 1'b0;
         r_irq_en    <= 1'b0;
         r_baud      <= 14'(DIV_RESET);
         r_overrun   <= 1'b0;
         r_frame_err <= 1'b0;
         r_rd_data   <= '0;
         r_rd_valid  <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         if (w_wr_ctrl) begin
            r_rx_en  <= wr_data[CTRL_RX_EN];
            r_irq_en <= wr_data[CTRL_IRQ_EN];
         end
         // Divisor is locked while the receiver runs.
         if (w_wr_baud && !r_rx_en) r_baud <= wr_data[13:0];
         r_overrun   <= w_overrun_set | (r_overrun & ~(w_wr_status & wr_data[STAT_OVERRUN]));
         r_frame_err <= w_frame_set | (r_frame_err & ~(w_wr_status & wr_data[STAT_FRAME_ERR]));
         r_rd_valid  <= rd_en;
         if (rd_en) r_rd_data <= w_rd_mux;
         r_irq <= r_irq_en & (!w_empty | r_overrun | r_frame_err);
      end
   end

   assign rd_data       = r_rd_data;
   assign rd_valid      = r_rd_valid;
   assign rx_enable     = r_rx_en;
   assign baud_tick_max = r_baud;
   assign irq           = r_irq;

endmodule

// File: doc/uart_rx_ctrl.md
# uart_rx_ctrl

Register-mapped controller for the UART receive datapath. It holds the baud divisor and receiver enable that configure the receiver, buffers received bytes in a small FIFO, and tracks overrun and framing-error status. A simple one-cycle register port connects it to the host, and it raises a level interrupt. It sits between the host bus and the UART receiver core.

## Interface
- `FIFO_DEPTH`, default 4: receive FIFO entries; power of two, minimum 2.
- `DIV_RESET`, default 10416: reset value of the baud divisor (100 MHz / 9600 baud).
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `wr_en`  in  1: register write strobe, one cycle per write.
- `rd_en`  in  1: register read strobe, one cycle per read.
- `addr`  in  2: register select; 0 CTRL, 1 BAUD, 2 STATUS, 3 DATA.
- `wr_data`  in  16: write data.
- `rd_data`  out  16: read data, valid while `rd_valid` is high.
- `rd_valid`  out  1: one-cycle pulse, one cycle after `rd_en`.
- `rx_byte`  in  8: received byte from the receiver core.
- `rx_done`  in  1: one-cycle pulse; `rx_byte` and `rx_frame_err` are valid.
- `rx_frame_err`  in  1: stop bit was sampled low for this frame.
- `rx_enable`  out  1: receiver enable, driven from CTRL bit 0.
- `baud_tick_max`  out  14: divisor to the receiver, driven from the BAUD register.
- `irq`  out  1: level interrupt.

## Operation
- CTRL (R/W): bit0 `rx_en`, bit1 `irq_en`. Reset value 0.
- BAUD (R/W): bits 13:0 hold the divisor; bits 15:14 read 0.
  - A write takes effect only when `rx_en` is 0 before the write.
  - A write while `rx_en` is 1 is ignored silently.
- STATUS:
  - Read-only bits: bit0 `not_empty`, bit1 `full`, bits 6:4 `count` (saturates at 7).
  - Sticky bits: bit2 `overrun`, bit3 `frame_err`. Writing 1 to a sticky bit clears it; writing 0 leaves it unchanged.
- DATA (RO):
  - A read returns the FIFO head in bits 7:0 and pops it.
  - A read on an empty FIFO returns 0, does not pop, and raises no error.
  - A write to DATA is ignored.
- Push: `rx_done` with `rx_frame_err`=0 pushes `rx_byte`. All of the following are accepted only when `rx_en`=1:
  - `rx_done` with `rx_frame_err`=1: set `frame_err`; do not push.
  - Push while full and no simultaneous pop: drop the byte and set `overrun`.
  - Push and pop in the same cycle while full: both succeed; `overrun` is not set.
  - Push and pop in the same cycle while empty: the pop returns 0, and the new byte is stored.
- Clearing `rx_en` keeps the FIFO contents and the sticky flags. Any `rx_done` that arrives afterwards is ignored.
- `irq` = `irq_en` & (`not_empty` | `overrun` | `frame_err`), registered.
- If `wr_en` and `rd_en` are asserted in the same cycle, both are performed. A read of STATUS returns the value from before the write.
- FIFO pointers are log2(`FIFO_DEPTH`)+1 bits wide and wrap modulo 2×`FIFO_DEPTH`. The extra bit distinguishes full from empty.

## Timing
- Reset values: `rd_data`=0, `rd_valid`=0, `rx_enable`=0, `baud_tick_max`=`DIV_RESET`, `irq`=0. FIFO empty; sticky bits 0.
- Writes update the registers on the rising edge where `wr_en` is sampled. `rx_enable` and `baud_tick_max` change on that same edge.
- Read latency is one cycle: `rd_en` at edge N gives `rd_valid`=1 and `rd_data` after edge N. `rd_data` holds its value until the next read.
- The pop occurs at the same edge as the DATA read sample. STATUS read in the following cycle reflects the pop.
- Push: FIFO state and STATUS update at the edge where `rx_done` is sampled. `irq` follows one edge later.
- Reset asserted mid-operation clears every state element immediately, including pending `rd_valid`.

## Structure
- Shared package `uart_pkg` holds:
  - Register addresses `UART_ADDR_CTRL`, `UART_ADDR_BAUD`, `UART_ADDR_STATUS`, `UART_ADDR_DATA`.
  - STATUS and CTRL bit positions.
  - `UART_DIV_9600_100M` = 10416.
- Sub-module `uart_rx_fifo`: synchronous FIFO with push/pop/full/empty/count. The register decode, the sticky flags and `irq` logic live in the top module.

## Test plan
- Reset, then read BAUD -> `rd_data`=10416, `rd_valid` exactly one cycle after `rd_en`. `irq`=0, `rx_enable`=0.
- Write BAUD=0x1000 with `rx_en`=0 -> `baud_tick_max`=0x1000. Set `rx_en`=1, write BAUD=0x0055 -> `baud_tick_max` stays 0x1000.
- With `rx_en`=1 and `irq_en`=1, push 0xA5 and 0x3C -> STATUS `count`=2 and `irq`=1. Two DATA reads return 0xA5 then 0x3C; then `not_empty`=0 and `irq`=0.
- Push 5 bytes 0x01..0x05 with no reads (depth 4) -> `full`=1, `overrun`=1, and DATA reads return 0x01..0x04. Write STATUS=0x0004 -> `overrun`=0.
- FIFO full, with a DATA read and an `rx_done` of 0x77 in the same cycle -> `overrun` stays 0, `count` stays 4, and the last entry read out is 0x77.
- `rx_done` with `rx_frame_err`=1 -> `frame_err`=1 and `count` unchanged. Assert reset mid-sequence -> all outputs return to their reset values.
